regread_arbiter: RTL
====================

// Module: regread_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for one shared 32x64 register-file read port.
//  The port's data path is a gate-level 32:1 mux tree with long propagation delay.
//  Grants one requester at a time, drives the mux select, holds it for SETTLE_CYCLES,
//  then captures the mux output and returns it with a one-cycle valid pulse.
//  Sits between the CPU read clients (decode A/B, debug, store-data) and the regfile.
// PARAMETERS
//  NUM_REQ        4   number of requesters, 2..8
//  SETTLE_CYCLES  8   cycles the select is held before capture, >=1; sized for mux path delay
//  XZR_BYPASS     1   1: address 31 (XZR) returns 64'h0 without settling
// PORTS
//  clk         in   1            rising-edge clock, sole clock
//  reset       in   1            synchronous, active-high reset
//  req         in   NUM_REQ      per-requester request level; held until its resp_valid
//  addr        in   NUM_REQ*5    packed register numbers; requester k uses addr[5k+4:5k]
//  rd_sel      out  5            select to the shared 32:1 read mux (registered)
//  rd_data     in   64           output of the shared read mux
//  gnt         out  NUM_REQ      one-hot grant (registered); zero when idle
//  resp_valid  out  NUM_REQ      one-cycle pulse to the granted requester
//  resp_data   out  64           captured read data; valid while resp_valid, held afterwards
//  busy        out  1            high in SETTLE and RESP states
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, cnt=0, rd_sel=0, gnt=0, resp_valid=0, resp_data=0, busy=0.
//  Reset mid-operation aborts silently; no resp_valid is issued for the lost grant.
//  FSM IDLE -> SETTLE -> RESP -> IDLE:
//   IDLE: if |req, win = first set req[] scanning ptr, ptr+1, ... mod NUM_REQ;
//     register gnt=onehot(win), rd_sel=addr[win], cnt=SETTLE_CYCLES-1.
//     Next state is RESP if XZR_BYPASS and addr[win]==31, else SETTLE. No req: stay IDLE.
//   SETTLE: rd_sel and gnt held stable. cnt decrements each cycle; when cnt==0,
//     resp_data<=rd_data and the next state is RESP.
//   RESP: resp_valid[win]=1 for exactly this cycle; ptr<=(win+1) mod NUM_REQ; gnt cleared
//     on exit; next state IDLE. Bypass path loads resp_data=64'h0 on entry to RESP.
//  Latency from the req-sampling edge in IDLE: resp_valid after SETTLE_CYCLES+1 cycles;
//   bypass after 1 cycle. Throughput: one read per SETTLE_CYCLES+2 cycles (bypass: 2).
//  rd_sel changes only on the IDLE->SETTLE/RESP edge. It holds its last value otherwise,
//   so the mux never sees a select change during settle.
//  addr is sampled once at grant; later changes to addr or a dropped req are ignored.
//   The response is still delivered to the granted requester.
//  A requester must not reassert a new request until it has seen resp_valid. It may
//   re-request in the cycle after resp_valid; that is treated as a new request.
//  Fairness: the requester just served has lowest priority next round. No starvation:
//   any held req is served within NUM_REQ grants.
//  Simultaneous requests in IDLE resolve by the ptr rotation above; no two gnt bits are ever set.
//  Out-of-range win is impossible: ptr wraps modulo NUM_REQ, also for non-power-of-2 NUM_REQ.
// STRUCTURE
//  regfile_pkg: REG_W=64, ADDR_W=5, NUM_REGS=32, XZR_ADDR=5'd31,
//   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RESP} rr_state_t.
//  Sub-module rr_picker #(N): combinational (req, ptr) -> (any, win index, onehot).
//  Top level holds the FSM, counter, ptr, and capture registers; cnt width is $clog2(SETTLE_CYCLES+1).
// TESTING
//  Run against the real gate-level 32:1 mux with regs preloaded X_k = 64'h1000+k; bench clk period
//   >= mux path delay / SETTLE_CYCLES.
//  1 Single: req=4'b0001, addr0=5 -> rd_sel=5 for 8 cycles; resp_valid=4'b0001 at +9, resp_data=64'h1005.
//  2 Contention: req=4'b1111, addrs 1,2,3,4, ptr=0 -> served in order 0,1,2,3 with data 1001..1004,
//    each spaced 10 cycles, one-hot gnt throughout.
//  3 Rotation: after serving req0, hold req0 and req2 -> req2 served next, then req0.
//  4 XZR: addr1=31, req=4'b0010 -> resp_valid[1] 1 cycle after sampling, resp_data=0, no SETTLE state.
//    With XZR_BYPASS=0, same stimulus -> normal 9-cycle path with mux data returned.
//  5 Stability: change addr0 from 5 to 9 and drop req0 during SETTLE -> rd_sel stays 5 and
//    resp_data=64'h1005 is delivered.
//  6 Reset mid-SETTLE: assert reset for 1 cycle -> all outputs 0 next edge, no resp_valid,
//    ptr=0; next req=4'b0100 is granted to requester 2.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the read-arbiter state type.
// Imported by the arbiter top and anything that talks to the 32x64 read port.
package regfile_pkg;

  localparam int REG_W    = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] XZR_ADDR = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RESP
  } rr_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after i_ptr,
// wrapping modulo N, so non-power-of-2 requester counts never produce a bad index.
module rr_picker #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic             o_any,
  output logic [PTR_W-1:0] o_win,
  output logic [N-1:0]     o_onehot
);

  // One spare bit so ptr+offset can exceed N-1 before folding back into range.
  logic [PTR_W:0] w_idx;

  always_comb begin
    o_any    = 1'b0;
    o_win    = '0;
    o_onehot = '0;
    w_idx    = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = {1'b0, i_ptr} + (PTR_W+1)'(i);
      if (w_idx >= (PTR_W+1)'(N)) begin
        w_idx = w_idx - (PTR_W+1)'(N);
      end
      if (!o_any && i_req[w_idx[PTR_W-1:0]]) begin
        o_any = 1'b1;
        o_win = w_idx[PTR_W-1:0];
      end
    end
    if (o_any) begin
      o_onehot[o_win] = 1'b1;
    end
  end

endmodule

// File: rtl/regread_arbiter.sv
// Round-robin arbiter for the shared 32:1 regfile read port: grants one client,
// holds the mux select while the slow mux path settles, then returns the captured data.
module regread_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter bit XZR_BYPASS    = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0]         rd_sel,
  input  logic [REG_W-1:0]          rd_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [REG_W-1:0]          resp_data,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  rr_state_t          r_state;
  rr_state_t          w_next;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_win;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_rdSel;
  logic [NUM_REQ-1:0] r_gnt;
  logic [REG_W-1:0]   r_respData;

  logic               w_any;
  logic [PTR_W-1:0]   w_win;
  logic [NUM_REQ-1:0] w_onehot;
  logic [ADDR_W-1:0]  w_winAddr;
  logic               w_isXzr;

  rr_picker #(.N(NUM_REQ), .PTR_W(PTR_W)) u_picker (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_any   (w_any),
    .o_win   (w_win),
    .o_onehot(w_onehot)
  );

  assign w_winAddr = addr[w_win*ADDR_W +: ADDR_W];
  assign w_isXzr   = XZR_BYPASS && (w_winAddr == XZR_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_any) w_next = w_isXzr ? ST_RESP : ST_SETTLE;
      ST_SETTLE: if (r_cnt == '0) w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Select and address are latched only at grant, so the mux never sees a select change mid-settle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr      <= '0;
      r_win      <= '0;
      r_cnt      <= '0;
      r_rdSel    <= '0;
      r_gnt      <= '0;
      r_respData <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_onehot;
            r_win   <= w_win;
            r_rdSel <= w_winAddr;
            r_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
            if (w_isXzr) begin
              r_respData <= '0;
            end
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_respData <= rd_data;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          r_gnt <= '0;
          r_ptr <= (r_win == PTR_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
        end
        default: begin
          r_gnt <= '0;
        end
      endcase
    end
  end

  assign rd_sel     = r_rdSel;
  assign gnt        = r_gnt;
  assign resp_valid = (r_state == ST_RESP) ? r_gnt : '0;
  assign resp_data  = r_respData;
  assign busy       = (r_state != ST_IDLE);

endmodule
